// File: rtl/mss_uart_pkg.sv
// Shared types and constants for the fabric-side MSS UART transmitter.
package mss_uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/mss_uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy output; full writes and empty reads are ignored.
module mss_uart_sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign w_push    = i_wr_en && (r_level != LW'(DEPTH));
  assign w_pop     = i_rd_en && (r_level != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/mss_uart_fabric_tx.sv
// Fabric-to-MSS UART transmitter: FIFO-buffered 8N1 serialiser, LSB first.
// Define MSS_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mss_uart_fabric_tx
  import mss_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [7:0]                    WR_DATA,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          TX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  tx_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_baud_cnt, w_cnt_nxt;
  logic [BW-1:0]     r_bit_cnt, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_txd, w_txd_nxt;
  logic              r_tx_done, w_done_nxt;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_fifo_nempty;
  logic [7:0]        w_rd_data;
  logic [LW-1:0]     w_level;

  mss_uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_wr_en   (WR_VALID && WR_READY),
    .i_wr_data (WR_DATA),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_level   (w_level)
  );

  assign WR_READY      = (w_level != LW'(FIFO_DEPTH));
  assign w_fifo_nempty = (w_level != '0);
  assign BUSY          = (r_state != IDLE) || w_fifo_nempty;
  assign FIFO_LEVEL    = w_level;
  assign TXD           = r_txd;
  assign TX_DONE       = r_tx_done;
  assign w_bit_end     = (r_baud_cnt == CW'(BAUD_DIV - 1));

`ifdef MSS_UART_TX_PARITY_EN
  logic r_parity;

  // Parity is captured at load time because the shifter discards data bits.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_rd_data;
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= IDLE_LEVEL;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_cnt_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_tx_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    if (r_state != IDLE) w_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + CW'(1);

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end
      START: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_txd_nxt   = r_shift[0];
        w_bit_nxt   = '0;
      end
      DATA: if (w_bit_end) begin
        w_bit_nxt = r_bit_cnt + BW'(1);
        if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef MSS_UART_TX_PARITY_EN
          w_state_nxt = PARITY;
          w_txd_nxt   = r_parity;
`else
          w_state_nxt = STOP;
          w_txd_nxt   = IDLE_LEVEL;
`endif
        end else begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_txd_nxt   = r_shift[1];
        end
      end
`ifdef MSS_UART_TX_PARITY_EN
      PARITY: if (w_bit_end) begin
        w_state_nxt = STOP;
        w_txd_nxt   = IDLE_LEVEL;
      end
`endif
      // Chain straight into the next start bit so back-to-back frames have no gap.
      STOP: if (w_bit_end) begin
        w_done_nxt = 1'b1;
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_mss_uart_fabric_tx.sv
// Randomised bench for mss_uart_fabric_tx against a frame-timing reference model.
module tb_mss_uart_fabric_tx;

  localparam int unsigned BAUD_DIV   = 4;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef MSS_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * BAUD_DIV;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] WR_DATA;
  logic       WR_VALID;
  logic       WR_READY;
  logic       TXD;
  logic       BUSY;
  logic       TX_DONE;
  logic [2:0] FIFO_LEVEL;

  mss_uart_fabric_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .WR_DATA    (WR_DATA),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .TX_DONE    (TX_DONE),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: pending bytes, the frame on the line and when it began.
  logic [7:0] q[$];
  logic [7:0] cur;
  int   cyc      = 0;
  int   start    = 0;
  bit   active   = 0;
  bit   exp_done = 0;
  bit   accepted = 0;
  bit   chk_en   = 0;
  int   n_frames = 0;
  int   n_done_obs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!active) return 1'b1;
    k = (cyc - start) / BAUD_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
`ifdef MSS_UART_TX_PARITY_EN
    if (k == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    bit push;
    if (!RESET_N) begin
      q.delete();
      active   = 0;
      exp_done = 0;
      accepted = 0;
    end else begin
      cyc++;
      push     = WR_VALID && (q.size() != FIFO_DEPTH);
      exp_done = 0;
      if (active && (cyc - start) == FRAME) begin
        exp_done = 1;
        active   = 0;
        n_frames++;
      end
      if (!active && q.size() != 0) begin
        cur    = q.pop_front();
        start  = cyc;
        active = 1;
      end
      if (push) q.push_back(WR_DATA);
      accepted = push;
    end
    #1;
    if (chk_en && RESET_N) begin
      check("txd",      32'(TXD),        32'(exp_txd()));
      check("tx_done",  32'(TX_DONE),    32'(exp_done));
      check("wr_ready", 32'(WR_READY),   32'(q.size() != FIFO_DEPTH));
      check("level",    32'(FIFO_LEVEL), 32'(q.size()));
      check("busy",     32'(BUSY),       32'(active || q.size() != 0));
      if (TX_DONE) n_done_obs++;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    WR_DATA  = b;
    WR_VALID = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!accepted && n < 500);
    check("push_timeout", 32'(accepted), 32'd1);
    WR_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || q.size() != 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int n;
    RESET_N  = 1'b0;
    WR_VALID = 1'b0;
    WR_DATA  = 8'h00;
    repeat (2) @(negedge CLK);
    check("rst_txd",      32'(TXD),        32'd1);
    check("rst_wr_ready", 32'(WR_READY),   32'd1);
    check("rst_busy",     32'(BUSY),       32'd0);
    check("rst_tx_done",  32'(TX_DONE),    32'd0);
    check("rst_level",    32'(FIFO_LEVEL), 32'd0);
    RESET_N = 1'b1;
    chk_en  = 1;
    @(negedge CLK);

    push_byte(8'h55);
    wait_idle();

    push_byte(8'hA3);
    push_byte(8'h0F);
    wait_idle();

`ifdef MSS_UART_TX_PARITY_EN
    push_byte(8'h07);
    push_byte(8'h03);
    wait_idle();
`endif

    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    wait_idle();

    for (int i = 0; i < 600; i++) begin
      WR_VALID = ($urandom_range(0, 2) == 0);
      WR_DATA  = 8'($urandom);
      @(negedge CLK);
    end
    WR_VALID = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3 of 0xFF with a second byte still queued.
    push_byte(8'hFF);
    push_byte(8'h12);
    n = 0;
    while (!(active && (cyc - start) / BAUD_DIV == 4) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reach_bit3", 32'(n < 200), 32'd1);
    check("pre_rst_level", 32'(FIFO_LEVEL), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst_txd",   32'(TXD),        32'd1);
    check("async_rst_level", 32'(FIFO_LEVEL), 32'd0);
    check("async_rst_busy",  32'(BUSY),       32'd0);
    q.delete();
    active = 0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (60) @(negedge CLK);

    push_byte(8'($urandom));
    wait_idle();

    check("done_count", 32'(n_done_obs), 32'(n_frames));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
